io_port_bridge: RTL

- External-side partner of the processor's I/O interface.
- Buffers words from an external producer and presents them on the processor's in_port.
- Captures words the processor writes on out_port and drains them to an external consumer through a valid/ready handshake.
- Raises the processor's interrupt line once per arriving input burst; sits beside Processor at the top level.

---
 rtl/io_port_bridge_pkg.sv | 19 +
 rtl/io_fifo.sv | 67 ++++++
 rtl/io_port_bridge.sv | 127 ++++++++++++
 3 files changed

// File: rtl/io_port_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_port_bridge_pkg
// Brief    : Shared defaults and interrupt FSM encoding for the I/O port bridge
// Revision : 1.0
// ============================================================================
package io_port_bridge_pkg;

    localparam int W_DEF     = 16;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2
    } int_state_t;

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_fifo
// Brief    : Synchronous FIFO; a push when full is taken only with a same-cycle pop
// Revision : 1.0
// ============================================================================
module io_fifo
    import io_port_bridge_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // When full with a pop, the write lands in the slot being read out this cycle.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/io_port_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_port_bridge
// Brief    : RX/TX buffering between processor I/O ports and external streams
// Revision : 1.0
// ============================================================================
module io_port_bridge
    import io_port_bridge_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int INT_HOLD = 2,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  ext_in_data,
    input  logic          ext_in_valid,
    output logic          ext_in_ready,
    output logic [W-1:0]  in_port,
    input  logic          cpu_in_re,
    output logic          interrupt,
    input  logic [W-1:0]  out_port,
    input  logic          cpu_out_we,
    output logic [W-1:0]  ext_out_data,
    output logic          ext_out_valid,
    input  logic          ext_out_ready,
    output logic [CW-1:0] rx_count,
    output logic          rx_underflow,
    output logic          tx_overflow
);

    localparam int HW = (INT_HOLD > 1) ? $clog2(INT_HOLD) : 1;

    logic [CW-1:0] w_rx_count;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_rx_push;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_tx_pop;
    logic [CW-1:0] w_tx_count;
    int_state_t    r_state;
    int_state_t    w_state_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_interrupt;
    logic          r_rx_underflow;
    logic          r_tx_overflow;

    assign ext_in_ready  = rst & ~w_rx_full;
    assign w_rx_push     = ext_in_valid & ext_in_ready;
    assign ext_out_valid = ~w_tx_empty;
    assign w_tx_pop      = ext_out_valid & ext_out_ready;

    io_fifo #(.W(W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (ext_in_data),
        .i_pop   (cpu_in_re),
        .o_data  (in_port),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    io_fifo #(.W(W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cpu_out_we),
        .i_data  (out_port),
        .i_pop   (w_tx_pop),
        .o_data  (ext_out_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    // One pulse per burst: WAIT blocks re-triggering until RX has fully drained.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_count != '0) begin
                    w_state_nxt = ST_ASSERT;
                    w_hold_nxt  = HW'(INT_HOLD - 1);
                end
            end
            ST_ASSERT: begin
                if (r_hold == '0) w_state_nxt = ST_WAIT;
                else              w_hold_nxt  = r_hold - HW'(1);
            end
            ST_WAIT: begin
                if (w_rx_count == '0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_hold         <= '0;
            r_interrupt    <= 1'b0;
            r_rx_underflow <= 1'b0;
            r_tx_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_interrupt <= (w_state_nxt == ST_ASSERT);
            if (cpu_in_re & w_rx_empty)              r_rx_underflow <= 1'b1;
            if (cpu_out_we & w_tx_full & ~w_tx_pop)  r_tx_overflow  <= 1'b1;
        end
    end

    assign interrupt    = r_interrupt;
    assign rx_count     = w_rx_count;
    assign rx_underflow = r_rx_underflow;
    assign tx_overflow  = r_tx_overflow;

    logic w_unused;
    assign w_unused = ^w_tx_count;

endmodule
`default_nettype wire
